// File: rtl/div32_seq.sv
// div32_seq: iterative restoring divider, one quotient bit per clock, signed/unsigned.
// Optional DIV_DZ_FLAG_EN adds the dz output and a single-cycle divide-by-zero path.
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             clrn_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sign_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] r_o,
    output logic             busy_o,
    output logic             ready_o
`ifdef DIV_DZ_FLAG_EN
    ,
    output logic             dz_o
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, a_q, q_q, r_q;
    logic             neg_q_q, neg_r_q, bz_q, busy_q, ready_q;
`ifdef DIV_DZ_FLAG_EN
    logic             dz_q;
    assign dz_o = dz_q;
`endif

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_d, quo_d, q_fin, r_fin, a_mag, b_mag;
    logic             last;

    assign q_o     = q_q;
    assign r_o     = r_q;
    assign busy_o  = busy_q;
    assign ready_o = ready_q;

    // The borrow bit of the (WIDTH+1)-bit trial subtract decides restore vs keep.
    always_comb begin
        a_mag = (sign_i && a_i[WIDTH-1]) ? -a_i : a_i;
        b_mag = (sign_i && b_i[WIDTH-1]) ? -b_i : b_i;
        trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        q_fin = bz_q ? '1 : (neg_q_q ? -quo_d : quo_d);
        r_fin = bz_q ? a_q : (neg_r_q ? -rem_d : rem_d);
`ifdef DIV_DZ_FLAG_EN
        last  = bz_q || (count_q == CW'(WIDTH - 1));
`else
        last  = (count_q == CW'(WIDTH - 1));
`endif
    end

    always_ff @(posedge clk_i or negedge clrn_i) begin
        if (!clrn_i) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            bz_q    <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
`ifdef DIV_DZ_FLAG_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    rem_q   <= '0;
                    quo_q   <= a_mag;
                    dvs_q   <= b_mag;
                    a_q     <= a_i;
                    neg_q_q <= sign_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    neg_r_q <= sign_i && a_i[WIDTH-1];
                    bz_q    <= (b_i == '0);
                    count_q <= '0;
                    busy_q  <= 1'b1;
                    state_q <= RUN;
                end
                RUN: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q + 1'b1;
                    if (last) begin
                        q_q     <= q_fin;
                        r_q     <= r_fin;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
`ifdef DIV_DZ_FLAG_EN
                        dz_q    <= bz_q;
`endif
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
